// File: rtl/gcode_cmd_queue.sv
// Command FIFO between the G-code parser and the motion controller, with a
// dispatch FSM that presents each command for a fixed hold window and then a gap.
module gcode_cmd_queue #(
    parameter int DEPTH       = 16,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 4,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [3:0]    wr_cmd,
    input  logic [13:0]   wr_x,
    input  logic [13:0]   wr_y,
    input  logic          flush,
    input  logic          block,
    input  logic          controller_ready,
    output logic [3:0]    cmd,
    output logic [13:0]   x_value_in,
    output logic [13:0]   y_value_in,
    output logic          memory_ready,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
    output logic          overflow
);

    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX) + 1;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        GAP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [31:0]     out_q, out_d;
    logic [31:0]     mem_q [DEPTH];

    logic            push;
    logic            pop;

    assign full         = (count_q == FULL_COUNT);
    assign empty        = (count_q == '0);
    assign wr_ready     = !full;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign memory_ready = (state_q == PRESENT);
    assign cmd          = out_q[31:28];
    assign x_value_in   = out_q[27:14];
    assign y_value_in   = out_q[13:0];

    // Flush takes priority over both the write and a pop in the same cycle.
    always_comb begin
        push       = wr_valid && !full && !flush;
        pop        = (state_q == IDLE) && !empty && controller_ready && !block && !flush;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
            if (wr_valid && full) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    out_d   = mem_q[rd_ptr_q];
                    state_d = PRESENT;
                    cnt_d   = '0;
                end
            end
            PRESENT: begin
                // A blocked command is abandoned; it has already left the FIFO.
                if (block || cnt_q == HOLD_LAST) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            out_q      <= out_d;
        end
    end

    // Storage array carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {wr_cmd, wr_x, wr_y};
        end
    end

endmodule

// File: tb/tb_gcode_cmd_queue.sv
// Self-checking bench for gcode_cmd_queue: directed scenarios plus random
// traffic, all compared cycle by cycle against a queue-based reference model.
module tb_gcode_cmd_queue;

    localparam int DEPTH = 16;
    localparam int HOLD  = 4;
    localparam int GAPC  = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [3:0]  wr_cmd = '0;
    logic [13:0] wr_x = '0;
    logic [13:0] wr_y = '0;
    logic        flush = 1'b0;
    logic        block = 1'b0;
    logic        controller_ready = 1'b0;
    logic [3:0]  cmd;
    logic [13:0] x_value_in;
    logic [13:0] y_value_in;
    logic        memory_ready;
    logic [4:0]  count;
    logic        empty;
    logic        full;
    logic        overflow;

    gcode_cmd_queue #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAPC)) dut (
        .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_cmd(wr_cmd), .wr_x(wr_x), .wr_y(wr_y), .flush(flush), .block(block),
        .controller_ready(controller_ready), .cmd(cmd), .x_value_in(x_value_in),
        .y_value_in(y_value_in), .memory_ready(memory_ready), .count(count),
        .empty(empty), .full(full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue plus countdowns of remaining hold/gap cycles.
    logic [31:0] mq[$];
    int          hold_left = 0;
    int          gap_left  = 0;
    logic [31:0] m_out = '0;
    bit          m_ovf = 1'b0;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        chk({tag, ".memory_ready"}, 32'(memory_ready), 32'(hold_left > 0));
        chk({tag, ".cmd"},          32'(cmd),          32'(m_out[31:28]));
        chk({tag, ".x"},            32'(x_value_in),   32'(m_out[27:14]));
        chk({tag, ".y"},            32'(y_value_in),   32'(m_out[13:0]));
        chk({tag, ".count"},        32'(count),        32'(mq.size()));
        chk({tag, ".empty"},        32'(empty),        32'(mq.size() == 0));
        chk({tag, ".full"},         32'(full),         32'(mq.size() == DEPTH));
        chk({tag, ".wr_ready"},     32'(wr_ready),     32'(mq.size() != DEPTH));
        chk({tag, ".overflow"},     32'(overflow),     32'(m_ovf));
    endtask

    task automatic applyStimulus(input bit wv, input logic [3:0] c, input logic [13:0] x,
                                 input logic [13:0] y, input bit fl, input bit blk,
                                 input bit cr, input string tag);
        bit was_full;
        bit idle;
        bit popm;
        wr_valid         = wv;
        wr_cmd           = c;
        wr_x             = x;
        wr_y             = y;
        flush            = fl;
        block            = blk;
        controller_ready = cr;
        was_full = (mq.size() == DEPTH);
        idle     = (hold_left == 0) && (gap_left == 0);
        popm     = 1'b0;
        if (fl) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            popm = idle && (mq.size() > 0) && cr && !blk;
            if (popm) m_out = mq.pop_front();
            if (wv && was_full) m_ovf = 1'b1;
            else if (wv) mq.push_back({c, x, y});
        end
        if (popm) begin
            hold_left = HOLD;
        end else if (hold_left > 0) begin
            if (blk) begin
                hold_left = 0;
                gap_left  = GAPC;
            end else begin
                hold_left--;
                if (hold_left == 0) gap_left = GAPC;
            end
        end else if (gap_left > 0) begin
            gap_left--;
        end
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic modelReset();
        mq.delete();
        hold_left = 0;
        gap_left  = 0;
        m_out     = '0;
        m_ovf     = 1'b0;
    endtask

    initial begin
        int          highs;
        int          rises;
        bit          prev;
        logic [31:0] got[$];
        logic [31:0] wexp;

        // Power-on reset
        modelReset();
        #2;
        checkOutput("reset");
        #15 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single command: load values and exact hold window
        applyStimulus(1, 4'd1, 14'd100, 14'd200, 0, 0, 1, "single_wr");
        applyStimulus(0, 0, 0, 0, 0, 0, 1, "single_pop");
        chk("single.cmd", 32'(cmd), 32'd1);
        chk("single.x", 32'(x_value_in), 32'd100);
        chk("single.y", 32'(y_value_in), 32'd200);
        highs = 1;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 1, "single_run");
            if (memory_ready === 1'b1) highs++;
        end
        chk("single.hold_cycles", 32'(highs), 32'(HOLD));

        // Fill past capacity, then drain and check order
        for (int i = 0; i < 17; i++)
            applyStimulus(1, 4'(i), 14'(i * 7 + 3), 14'(i * 13 + 1), 0, 0, 0, "fill");
        chk("fill.count", 32'(count), 32'd16);
        chk("fill.full", 32'(full), 32'd1);
        chk("fill.overflow", 32'(overflow), 32'd1);
        chk("fill.wr_ready", 32'(wr_ready), 32'd0);
        prev = 1'b0;
        got.delete();
        for (int i = 0; i < 170; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 1, "drain");
            if (memory_ready === 1'b1 && !prev) got.push_back({cmd, x_value_in, y_value_in});
            prev = memory_ready;
        end
        chk("drain.entries", 32'(got.size()), 32'd16);
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            wexp = {4'(i), 14'(i * 7 + 3), 14'(i * 13 + 1)};
            chk("drain.order", got[i], wexp);
        end

        // Wrap with simultaneous push/pop while near full
        for (int i = 0; i < 16; i++)
            applyStimulus(1, 4'(15 - i), 14'(i + 500), 14'(i + 900), 0, 0, 0, "wrap_fill");
        for (int i = 0; i < 60; i++)
            applyStimulus(!full, 4'(i), 14'(i + 1000), 14'(i + 2000), 0, 0, 1, "wrap_mix");

        // Block on the second PRESENT cycle
        applyStimulus(1, 0, 0, 0, 1, 0, 0, "blk_flush");
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, "blk_settle");
        applyStimulus(1, 4'd5, 14'd55, 14'd66, 0, 0, 0, "blk_wr1");
        applyStimulus(1, 4'd6, 14'd77, 14'd88, 0, 0, 0, "blk_wr2");
        for (int i = 0; i < 40 && memory_ready !== 1'b1; i++)
            applyStimulus(0, 0, 0, 0, 0, 0, 1, "blk_wait");
        chk("blk.present_reached", 32'(memory_ready), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, "blk_second");
        applyStimulus(0, 0, 0, 0, 0, 1, 1, "blk_assert");
        chk("blk.mr_drop", 32'(memory_ready), 32'd0);
        highs = 0;
        for (int i = 0; i < 15; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, 1, "blk_hold");
            if (memory_ready === 1'b1) highs++;
        end
        chk("blk.no_dispatch", 32'(highs), 32'd0);
        chk("blk.count_kept", 32'(count), 32'd1);
        for (int i = 0; i < 20 && memory_ready !== 1'b1; i++)
            applyStimulus(0, 0, 0, 0, 0, 0, 1, "blk_release");
        chk("blk.next_cmd", 32'(cmd), 32'd6);

        // Flush with a simultaneous write
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, "fl_settle");
        for (int i = 0; i < 5; i++)
            applyStimulus(1, 4'(i + 9), 14'(i), 14'(i), 0, 0, 0, "fl_wr");
        applyStimulus(1, 4'd3, 14'd3, 14'd3, 1, 0, 0, "fl_flush");
        chk("fl.count", 32'(count), 32'd0);
        chk("fl.empty", 32'(empty), 32'd1);
        chk("fl.overflow", 32'(overflow), 32'd0);
        rises = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 1, "fl_after");
            if (memory_ready === 1'b1) rises++;
        end
        chk("fl.no_dispatch", 32'(rises), 32'd0);
        chk("fl.cmd_kept", 32'(cmd), 32'd6);

        // Random traffic
        for (int i = 0; i < 400; i++)
            applyStimulus($urandom_range(0, 99) < 55, 4'($urandom), 14'($urandom), 14'($urandom),
                          $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 10,
                          $urandom_range(0, 99) < 70, "random");

        // Asynchronous reset in the middle of a dispatch
        applyStimulus(0, 0, 0, 0, 1, 0, 0, "rst_flush");
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, "rst_settle");
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 4'(i + 2), 14'(i + 40), 14'(i + 60), 0, 0, 0, "rst_wr");
        for (int i = 0; i < 40 && memory_ready !== 1'b1; i++)
            applyStimulus(0, 0, 0, 0, 0, 0, 1, "rst_wait");
        chk("rst.present_reached", 32'(memory_ready), 32'd1);
        chk("rst.queued", 32'(count), 32'd3);
        #2 reset_n = 1'b0;
        modelReset();
        #1;
        checkOutput("rst_async");
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1, 4'd12, 14'd1234, 14'd4321, 0, 0, 1, "post_rst_wr");
        chk("post_rst.no_early", 32'(memory_ready), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, "post_rst_pop");
        chk("post_rst.cmd", 32'(cmd), 32'd12);
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1, "post_rst_run");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
